// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - RV64 load/store unit converting byte requests into doubleword memory accesses
module mem_lsu #(
    parameter int Nbits = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [Nbits-1:0] req_addr,
    input  logic [Nbits-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [Nbits-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             mem_w_en,
    output logic             mem_r_en,
    output logic [Nbits-1:0] mem_address,
    output logic [Nbits-1:0] mem_w_data,
    input  logic [Nbits-1:0] mem_r_data
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, ERR, RESP} state_t;

    state_t           state, state_n;
    logic             we_q;
    logic [2:0]       f3_q;
    logic [Nbits-1:0] addr_q;
    logic [Nbits-1:0] wdata_q;
    logic [Nbits-1:0] merged_q;

    logic             accept;
    logic             illegal_req;
    logic             misaligned_req;
    logic [5:0]       lane_shift;
    logic [Nbits-1:0] size_mask;
    logic [Nbits-1:0] lane_mask;
    logic [Nbits-1:0] shifted;
    logic [Nbits-1:0] load_ext;
    logic [Nbits-1:0] merged;

    assign accept     = req_valid && (state == IDLE);
    assign lane_shift = {addr_q[2:0], 3'b000};

    // Classify the incoming request before it is latched
    always_comb begin
        illegal_req = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
        case (req_funct3[1:0])
            2'b01:   misaligned_req = req_addr[0];
            2'b10:   misaligned_req = |req_addr[1:0];
            2'b11:   misaligned_req = |req_addr[2:0];
            default: misaligned_req = 1'b0;
        endcase
    end

    // Lane extraction for loads and lane merge for sub-doubleword stores
    always_comb begin
        case (f3_q[1:0])
            2'b00:   size_mask = {{(Nbits-8){1'b0}}, 8'hFF};
            2'b01:   size_mask = {{(Nbits-16){1'b0}}, 16'hFFFF};
            2'b10:   size_mask = {{(Nbits-32){1'b0}}, 32'hFFFF_FFFF};
            default: size_mask = {Nbits{1'b1}};
        endcase
        lane_mask = size_mask << lane_shift;
        shifted   = mem_r_data >> lane_shift;
        merged    = (mem_r_data & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
        case (f3_q)
            3'b000:  load_ext = {{(Nbits-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{(Nbits-16){shifted[15]}}, shifted[15:0]};
            3'b010:  load_ext = {{(Nbits-32){shifted[31]}}, shifted[31:0]};
            3'b100:  load_ext = {{(Nbits-8){1'b0}}, shifted[7:0]};
            3'b101:  load_ext = {{(Nbits-16){1'b0}}, shifted[15:0]};
            3'b110:  load_ext = {{(Nbits-32){1'b0}}, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    // State register, request latch and registered response fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= '0;
            merged_q  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                we_q      <= req_we;
                f3_q      <= req_funct3;
                addr_q    <= req_addr;
                wdata_q   <= req_wdata;
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
            case (state)
                LOAD:    rsp_rdata <= load_ext;
                RMW_RD:  merged_q  <= merged;
                WRITE:   rsp_rdata <= '0;
                ERR: begin
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                end
                default: ;
            endcase
        end
    end

    // Next-state selection and memory/handshake decode from current state
    always_comb begin
        state_n     = state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        mem_r_en    = 1'b0;
        mem_w_en    = 1'b0;
        mem_address = '0;
        mem_w_data  = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (illegal_req || misaligned_req) state_n = ERR;
                    else if (!req_we)                  state_n = LOAD;
                    else if (req_funct3[1:0] == 2'b11) state_n = WRITE;
                    else                               state_n = RMW_RD;
                end
            end
            LOAD: begin
                mem_r_en    = 1'b1;
                mem_address = {3'b000, addr_q[Nbits-1:3]};
                state_n     = RESP;
            end
            RMW_RD: begin
                mem_r_en    = 1'b1;
                mem_address = {3'b000, addr_q[Nbits-1:3]};
                state_n     = WRITE;
            end
            WRITE: begin
                mem_w_en    = 1'b1;
                mem_address = {3'b000, addr_q[Nbits-1:3]};
                mem_w_data  = (we_q && f3_q[1:0] == 2'b11) ? wdata_q : merged_q;
                state_n     = RESP;
            end
            ERR:  state_n = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
